// File: rtl/merge_run_feeder.sv
// Source end of a 2:1 merge layer. It collects run A and then run B from a serial stream.
// It then presents the head of each run, with valid/last flags, to a consumer that pops them.
module merge_run_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int RUN_LEN    = 4,
  parameter int CNT_W      = $clog2(RUN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] head_a,
  output logic [DATA_WIDTH-1:0] head_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  last_a,
  output logic                  last_b,
  input  logic                  pop_a,
  input  logic                  pop_b,
  output logic                  done
);

  localparam int IDX_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {FILL_A, FILL_B, STREAM} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem_a [RUN_LEN];
  logic [DATA_WIDTH-1:0] mem_b [RUN_LEN];
  logic [CNT_W-1:0]      wr_cnt, rd_a, rd_b;
  logic [CNT_W-1:0]      rd_a_nxt, rd_b_nxt;
  logic                  accept, streaming;

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    streaming = (state == STREAM);
    accept    = in_valid && in_ready;
    valid_a   = streaming && (rd_a < LEN_C);
    valid_b   = streaming && (rd_b < LEN_C);
    last_a    = valid_a && (rd_a == LAST_C);
    last_b    = valid_b && (rd_b == LAST_C);
    head_a    = '0;
    head_b    = '0;
    if (valid_a) head_a = mem_a[rd_a[IDX_W-1:0]];
    if (valid_b) head_b = mem_b[rd_b[IDX_W-1:0]];
    // A pop of an empty run is dropped here, so the read counter cannot move past RUN_LEN.
    rd_a_nxt  = (pop_a && valid_a) ? rd_a + ONE_C : rd_a;
    rd_b_nxt  = (pop_b && valid_b) ? rd_b + ONE_C : rd_b;
  end

  // NOTE: the run storage has no reset. Reset clears the counters, which makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (accept && state == FILL_A) mem_a[wr_cnt[IDX_W-1:0]] <= in_data;
    if (accept && state == FILL_B) mem_b[wr_cnt[IDX_W-1:0]] <= in_data;
  end

  // NOTE: state registers use non-blocking assignments, so every update reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL_A;
      wr_cnt   <= '0;
      rd_a     <= '0;
      rd_b     <= '0;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        FILL_A: if (accept) begin
          if (wr_cnt == LAST_C) begin
            wr_cnt <= '0;
            state  <= FILL_B;
          end else begin
            wr_cnt <= wr_cnt + ONE_C;
          end
        end
        FILL_B: if (accept) begin
          if (wr_cnt == LAST_C) begin
            wr_cnt   <= '0;
            rd_a     <= '0;
            rd_b     <= '0;
            in_ready <= 1'b0;
            state    <= STREAM;
          end else begin
            wr_cnt <= wr_cnt + ONE_C;
          end
        end
        STREAM: begin
          rd_a <= rd_a_nxt;
          rd_b <= rd_b_nxt;
          // The done pulse and the return to filling happen together, as soon as both runs drain.
          if (rd_a_nxt == LEN_C && rd_b_nxt == LEN_C) begin
            done     <= 1'b1;
            in_ready <= 1'b1;
            state    <= FILL_A;
          end
        end
        default: begin
          state    <= FILL_A;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
